// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link, used by both the receive-side
// demultiplexer and the transmit-side mux sequencer.
package tdm_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// Slot counter: advances on each accepted beat, and jumps to 1 when a
// frame_start beat is taken as slot 0.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              load_i,
   output logic [SLOT_W-1:0] slot_o
);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   // Next-count selection: a load takes priority over a plain increment.
   always_comb begin
      slot_d = slot_q;
      if (load_i) begin
         slot_d = SLOT_W'(1);
      end else if (en_i) begin
         slot_d = slot_q + SLOT_W'(1);
      end else begin
         slot_d = slot_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: aligns to frame_start, gathers four beats
// and presents them as one parallel word with a single-cycle valid strobe.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      din,
   input  logic              din_valid,
   input  logic              frame_start,
   output logic [4*W-1:0]    d_out,
   output logic              out_valid,
   output logic [SLOT_W-1:0] slot,
   output logic              locked,
   output logic              sync_err
);

   tdm_state_e          state_q, state_d;
   logic [2:0][W-1:0]   hold_q, hold_d;
   logic [4*W-1:0]      d_out_q, d_out_d;
   logic                out_valid_q, out_valid_d;
   logic                sync_err_q, sync_err_d;
   logic [SLOT_W-1:0]   slot_s;
   logic                slot_en_s;
   logic                slot_load_s;

   tdm_slot_ctr u_slot_ctr (
      .clk    (clk),
      .rst    (rst),
      .en_i   (slot_en_s),
      .load_i (slot_load_s),
      .slot_o (slot_s)
   );

   // Beat acceptance, realignment and frame completion.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      d_out_d     = d_out_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;
      slot_en_s   = 1'b0;
      slot_load_s = 1'b0;
      if (din_valid) begin
         if (frame_start) begin
            // A marker always restarts the frame at slot 0, even when locked.
            slot_load_s = 1'b1;
            state_d     = LOCKED;
            hold_d[0]   = din;
            if ((state_q == LOCKED) && (slot_s != SLOT_W'(0))) begin
               sync_err_d = 1'b1;
            end else begin
               sync_err_d = 1'b0;
            end
         end else if (state_q == LOCKED) begin
            slot_en_s = 1'b1;
            case (slot_s)
               2'd0: hold_d[0] = din;
               2'd1: hold_d[1] = din;
               2'd2: hold_d[2] = din;
               2'd3: begin
                  d_out_d     = {din, hold_q[2], hold_q[1], hold_q[0]};
                  out_valid_d = 1'b1;
               end
               default: hold_d = hold_q;
            endcase
         end else begin
            slot_en_s = 1'b0;
         end
      end else begin
         slot_en_s = 1'b0;
      end
   end

   // State, hold and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         d_out_q     <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         d_out_q     <= d_out_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign d_out     = d_out_q;
   assign out_valid = out_valid_q;
   assign slot      = slot_s;
   assign locked    = (state_q == LOCKED);
   assign sync_err  = sync_err_q;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-collecting model predicts each
// cycle's status and completed words; a monitor pops and compares.
module tb_tdm_demux4;

   localparam int W = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   din;
   logic           din_valid;
   logic           frame_start;
   logic [4*W-1:0] d_out;
   logic           out_valid;
   logic [1:0]     slot;
   logic           locked;
   logic           sync_err;

   always #5 clk = ~clk;

   tdm_demux4 #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .d_out       (d_out),
      .out_valid   (out_valid),
      .slot        (slot),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   typedef struct packed {
      logic [1:0] slot;
      logic       locked;
      logic       ov;
      logic       se;
   } st_t;

   st_t            st_q[$];
   logic [4*W-1:0] frm_q[$];
   logic [W-1:0]   m_frame[$];
   bit             m_locked = 1'b0;
   logic [4*W-1:0] mon_last = '0;
   int             n_chk = 0;
   int             n_fail = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected status per driven cycle, checked after the edge.
   always @(posedge clk) begin
      st_t e;
      #1;
      if (st_q.size() > 0) begin
         e = st_q.pop_front();
         check("slot", 32'(slot), 32'(e.slot));
         check("locked", 32'(locked), 32'(e.locked));
         check("out_valid", 32'(out_valid), 32'(e.ov));
         check("sync_err", 32'(sync_err), 32'(e.se));
         if (e.ov && (frm_q.size() > 0)) mon_last = frm_q.pop_front();
         check("d_out", 32'(d_out), 32'(mon_last));
      end
   end

   // Drive one cycle and predict its effect from the frame-level rules.
   task automatic drive(bit v, bit fs, logic [W-1:0] d);
      st_t            e;
      logic [4*W-1:0] word;
      e = '0;
      @(negedge clk);
      din_valid   = v;
      frame_start = fs;
      din         = d;
      if (v) begin
         if (fs) begin
            if (m_locked && (m_frame.size() != 0)) e.se = 1'b1;
            m_frame.delete();
            m_frame.push_back(d);
            m_locked = 1'b1;
         end else if (m_locked) begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
               word = '0;
               for (int k = 0; k < 4; k++) word[W*k +: W] = m_frame[k];
               frm_q.push_back(word);
               e.ov = 1'b1;
               m_frame.delete();
            end
         end
      end
      e.slot   = 2'(m_frame.size());
      e.locked = m_locked;
      st_q.push_back(e);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_d_out"}, 32'(d_out), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_slot"}, 32'(slot), 32'd0);
      check({tag, "_locked"}, 32'(locked), 32'd0);
      check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      din_valid   = 1'b0;
      frame_start = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      m_frame.delete();
      m_locked = 1'b0;
      mon_last = '0;
      st_q.delete();
      frm_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      din_valid   = 1'b0;
      frame_start = 1'b0;
      din         = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Beats before any marker are dropped, then an aligned 1,1,0,0 frame.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, W'($urandom_range(0, 1)));
      drive(1'b1, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // Aligned 0,1,0,1 then free-running 0,0,1,1 back to back.
      drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);

      // Gap of three idle cycles before the last beat; stray marker ignored.
      drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1); drive(1'b0, 1'b1, 1'b1); drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);

      // Marker on the third beat realigns; 1,1,1 completes the new frame.
      drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);

      // Reset asserted mid-frame.
      drive(1'b1, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b0);
      do_reset();

      // Randomized traffic: mostly aligned markers, occasional misaligned ones.
      for (int i = 0; i < 3000; i++) begin
         bit v;
         bit fs;
         v  = ($urandom_range(0, 3) != 0);
         if (m_frame.size() == 0) fs = ($urandom_range(0, 1) == 1);
         else                     fs = ($urandom_range(0, 15) == 0);
         drive(v, fs, W'($urandom_range(0, (1 << W) - 1)));
         if (i == 1500) do_reset();
      end

      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("status_q_drained", 32'(st_q.size()), 32'd0);
      check("frame_q_drained", 32'(frm_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_tdm_demux4

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a link whose transmit end is a 4:1 mux stepping its select through slots 0..3. The block takes one W-bit beat per valid cycle, aligns to a frame-start marker and tracks the slot number. It collects four beats per frame and presents them as a parallel word with a one-cycle valid strobe. It sits between the serial link and any consumer of per-channel data.

## Interface
- W, default 1: data width per channel, legal range 1..16.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  incoming beat for the current slot.
- din_valid  input  1  din carries a beat this cycle.
- frame_start  input  1  qualified by din_valid; marks the current beat as slot 0.
- d_out  output  4*W  last complete frame; channel k at d_out[W*k +: W].
- out_valid  output  1  one-cycle pulse; d_out updated this cycle.
- slot  output  2  slot index the next valid beat will occupy.
- locked  output  1  high while aligned to a frame.
- sync_err  output  1  one-cycle pulse on a misaligned frame_start.

The interface above fixes one clock, clk, and an asynchronous active-high reset, rst.

## Operation
- Two states.
  - IDLE: no alignment.
  - LOCKED: aligned.
  - Reset enters IDLE.
- In IDLE:
  - Beats without frame_start are dropped; slot stays 0.
  - A beat with frame_start is stored as slot 0; slot becomes 1; state goes to LOCKED.
- In LOCKED, each valid beat is stored into the hold register for the current slot, then slot increments modulo 4.
- When the slot-3 beat is accepted, the frame is complete:
  - On the next edge, d_out loads hold0..hold2 plus that slot-3 beat.
  - out_valid pulses.
- frame_start with a valid beat while in LOCKED:
  - If slot==0: the expected case, no error.
  - If slot!=0: sync_err pulses and the partial frame is discarded, with no out_valid. The beat is stored as slot 0 and slot becomes 1; the block stays LOCKED (realign).
- frame_start without din_valid is ignored.
- A frame_start-free beat at slot 0 in LOCKED is accepted as a normal slot 0 (free-running frames).
- d_out holds its value between frames. Only a completed frame changes it.
- Hold registers are not cleared on realign; they are overwritten as the new frame fills.

## Timing
- Reset values:
  - d_out=0, out_valid=0, slot=0, locked=0, sync_err=0.
  - Hold registers are 0 and state is IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: out_valid is high in the cycle after the edge that samples the slot-3 beat.
- out_valid and sync_err are each high for exactly one cycle per event.
- Both pulses can occur back-to-back across consecutive frames; they never coincide on the same cycle.
- din_valid may drop for any number of cycles mid-frame. slot and hold registers then hold.
- Full throughput is one frame per 4 valid cycles.
- locked follows the state register: it rises on the edge that samples the first frame_start beat.
- Reset asserted mid-frame: the partial frame is discarded, and the block returns to IDLE immediately and asynchronously.

## Structure
- Shared package tdm_pkg holds:
  - NUM_SLOTS=4 and SLOT_W=2.
  - The state typedef with IDLE and LOCKED.
- This package is shared with the matching transmit-side mux sequencer.
- One natural sub-module, tdm_slot_ctr: 2-bit slot counter with enable (din_valid) and synchronous load-to-1 (frame_start). The remaining logic stays in the top module.

## Test plan
All scenarios use W=1.
- Reset: assert rst mid-run -> all outputs 0 and locked=0 within the same cycle.
- Aligned frame: beats 0,1,0,1 with frame_start on the first -> d_out=4'b1010, out_valid pulse one cycle after the 4th beat, locked=1.
- Back-to-back frames:
  - Stimulus: 1010, then 1100 (slot order 0,0,1,1) with no frame_start on the second.
  - Required: d_out=1010 then 1100, two out_valid pulses 4 cycles apart, no sync_err.
- Gaps: frame 0,1,0,1 with din_valid low 3 cycles between beats 2 and 3 -> d_out=1010 once, slot holds at 2 during the gap.
- Misalignment: frame_start on the 3rd beat of a frame -> sync_err pulse, no out_valid for that frame, slot=1. The following 3 beats 1,1,1 complete d_out with slot0 = the realign beat.
- IDLE drop: 5 beats without frame_start after reset -> no out_valid, slot=0, locked=0. Then an aligned frame 1,1,0,0 gives d_out=4'b0011.
